// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register scoreboard with stall, issue and forwarding selects; optional macro HAZARD_SCOREBOARD_FWD_EN
module hazard_scoreboard #(
    parameter int NREG       = 64,
    parameter int RW         = $clog2(NREG),
    parameter int RETIRE_AGE = 3,
    parameter int FW         = $clog2(RETIRE_AGE + 1),
    parameter int LW         = $clog2(RETIRE_AGE + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          advance,
    input  logic          flush,
    input  logic          d_valid,
    input  logic [RW-1:0] d_rs0,
    input  logic [RW-1:0] d_rs1,
    input  logic          d_rs0_used,
    input  logic          d_rs1_used,
    input  logic [RW-1:0] d_rd,
    input  logic          d_regwrite,
    input  logic [LW-1:0] d_lat,
    output logic          stall,
    output logic          issue,
    output logic [FW-1:0] fwd0,
    output logic [FW-1:0] fwd1
);

    localparam logic [FW-1:0] AGE_MAX = FW'(RETIRE_AGE);
    localparam logic [LW-1:0] LAT_MAX = LW'(RETIRE_AGE);

    logic [NREG-1:0] busy_q, busy_d;
    logic [FW-1:0]   age_q [NREG];
    logic [FW-1:0]   age_d [NREG];
    logic [LW-1:0]   rem_q [NREG];
    logic [LW-1:0]   rem_d [NREG];

    logic            src0_busy, src1_busy;
    logic            haz0, haz1;
    logic            wr_en;
    logic [LW-1:0]   lat_eff;

    // Source lookup: busy visibility is masked by rstn so outputs read as empty during reset
    always_comb begin
        src0_busy = rstn & d_rs0_used & (d_rs0 != '0) & busy_q[d_rs0];
        src1_busy = rstn & d_rs1_used & (d_rs1 != '0) & busy_q[d_rs1];
`ifdef HAZARD_SCOREBOARD_FWD_EN
        haz0 = src0_busy & (rem_q[d_rs0] != '0);
        haz1 = src1_busy & (rem_q[d_rs1] != '0);
        fwd0 = (src0_busy & ~haz0) ? age_q[d_rs0] : '0;
        fwd1 = (src1_busy & ~haz1) ? age_q[d_rs1] : '0;
`else
        haz0 = src0_busy;
        haz1 = src1_busy;
        fwd0 = '0;
        fwd1 = '0;
`endif
        stall = d_valid & ~flush & (haz0 | haz1);
        issue = d_valid & advance & ~stall & ~flush;
    end

    // Latency normalisation: 0 behaves as 1, anything beyond the retire age is clamped
    always_comb begin
        if (d_lat == '0) begin
            lat_eff = LW'(1);
        end else if (d_lat > LAT_MAX) begin
            lat_eff = LAT_MAX;
        end else begin
            lat_eff = d_lat;
        end
        wr_en = issue & d_regwrite & (d_rd != '0);
    end

    // Entry ageing/retirement on advance, then the newly issued writer overrides its register
    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        rem_d  = rem_q;
        if (advance) begin
            for (int i = 0; i < NREG; i++) begin
                if (busy_q[i]) begin
                    if ((age_q[i] == AGE_MAX) && (rem_q[i] == '0)) begin
                        busy_d[i] = 1'b0;
                        age_d[i]  = '0;
                        rem_d[i]  = '0;
                    end else begin
                        age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + 1'b1;
                        rem_d[i] = (rem_q[i] == '0) ? '0 : rem_q[i] - 1'b1;
                    end
                end
            end
        end
        if (wr_en) begin
            busy_d[d_rd] = 1'b1;
            age_d[d_rd]  = FW'(1);
            rem_d[d_rd]  = lat_eff - 1'b1;
        end
    end

    // State registers with synchronous active-low reset clearing every entry
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
            age_q  <= '{default: '0};
            rem_q  <= '{default: '0};
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register scoreboard and hazard controller for the in-order pipeline. It replaces fixed E/M-stage comparators with per-register tracking of in-flight writers. It produces forwarding selects, a decode stall and issue acceptance for producers of variable latency (ALU, load, FPU). It sits beside decode and consumes the pipeline's global advance and branch-flush signals.

## Interface
Parameters:
- NREG, 64: architectural registers tracked (integer + float file).
- RW, $clog2(NREG): register index width.
- RETIRE_AGE, 3: advances from issue until the write is visible in the register file (E, M, W).
- FW, $clog2(RETIRE_AGE+1): forwarding-select width.
- LW, $clog2(RETIRE_AGE+1): latency field width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- advance  in  1  pipeline moves one stage this cycle (0 = global freeze, e.g. cache miss).
- flush  in  1  branch/jump miss; squashes the instruction in decode.
- d_valid  in  1  decode holds a valid instruction.
- d_rs0, d_rs1  in  RW  source indices.
- d_rs0_used, d_rs1_used  in  1  source actually read.
- d_rd  in  RW  destination index.
- d_regwrite  in  1  instruction writes d_rd.
- d_lat  in  LW  advances after issue until the result is forwardable (ALU 1, load 2).
- stall  out  1  decode must hold; a bubble enters E.
- issue  out  1  instruction accepted this cycle.
- fwd0, fwd1  out  FW  source select: 0 = register file, k = result of the entry at age k (1 = E, 2 = M, 3 = W).

## Operation
- Per-register state: busy, age (1..RETIRE_AGE), rem (0..RETIRE_AGE-1).
- Index 0 is never tracked. A write to r0 creates no entry, and a read of r0 gives fwd=0 with no stall.
- Source hazard: the source is used, its entry is busy and rem>0. stall = d_valid & ~flush & (hazard on rs0 | hazard on rs1).
- fwdN = busy ? age : 0 when the source is used and not hazarded; otherwise 0.
- issue = d_valid & advance & ~stall & ~flush.
- On an advance edge, every busy entry updates: age saturates at RETIRE_AGE, and rem decrements, saturating at 0.
- An entry clears on an advance edge when age==RETIRE_AGE and rem==0.
- Issue with d_regwrite and d_rd!=0 sets the entry for d_rd: busy=1, age=1, rem=max(d_lat,1)-1.
- d_lat>RETIRE_AGE is clamped to RETIRE_AGE. d_lat=0 is treated as 1.
- Issue overwrites an existing entry for the same register (WAW): the newer writer shadows the older. Issue takes priority over that register's age/retire update in the same cycle.
- When advance=0, all state holds. stall and fwd still evaluate combinationally.
- A flush issues nothing that cycle. Existing entries belong to older instructions and keep advancing.

## Timing
- stall, issue and fwd are combinational from the inputs and current state. All state changes occur at posedge clk.
- Reset: all busy=0, so stall=0, issue=d_valid&advance&~flush, and fwd0=fwd1=0 whenever rstn is low.
- Reset mid-operation clears every entry on that edge. No partial retirement occurs.
- ALU producer (lat 1): a consumer in the next cycle sees fwd=1 with no stall.
- Load producer (lat 2): an immediate consumer stalls exactly one advancing cycle, then sees fwd=2.
- Register-file visibility: fwd returns to 0 on the advance after age reaches RETIRE_AGE.

## Configuration
- HAZARD_SCOREBOARD_FWD_EN defined: forwarding enabled as described.
- HAZARD_SCOREBOARD_FWD_EN undefined: fwd0/fwd1 are tied to 0, and any used source with busy=1 stalls until its entry clears. The age/rem logic is retained only for retirement.

## Test plan
- ALU chain: issue rd=5, lat=1 → next cycle, rs0=5 gives fwd0=1 and stall=0; a further consumer one cycle later gives fwd0=2.
- Load-use: issue rd=7, lat=2 → next cycle, rs1=7 gives stall=1 and issue=0. The following cycle gives stall=0 and fwd1=2.
- Freeze: issue rd=3, then advance=0 for 3 cycles → fwd0 stays 1 for rs0=3. After advance returns, the progression is 2, 3, then 0.
- Flush: d_valid=1, rd=9, flush=1 → issue=0. The next cycle, rs0=9 gives fwd0=0.
- r0 and WAW: a write to rd=0 yields fwd=0 afterward. Issue rd=4 lat=2, then rd=4 lat=1 → the next reader of r4 sees fwd=1 with no stall.
- FWD_EN undefined: issue rd=5, then rs0=5 → stall=1 for 3 advancing cycles, then issue=1 with fwd0=0.
